csr_launcher: RTL and testbench

CSR_LAUNCHER -- requirements
Module: csr_launcher

---
 rtl/csr_launcher_if.sv | 11 +
 rtl/csr_launcher.sv | 140 ++++++++++++++
 tb/tb_csr_launcher.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_launcher_if.sv
// Valid/ready write bus between the launcher and the accelerator CSR ports.
interface bus_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport mst_port (output valid, output data, input ready);
  modport slv_port (input valid, input data, output ready);
endinterface

// File: rtl/csr_launcher.sv
// Sequences one accelerator launch: program vector length and column count, set run,
// wait for the accelerator to go busy and then idle again, clear run, report done/error.
module csr_launcher #(
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_rows,
  input  logic [7:0] cmd_cols,
  bus_if.mst_port    vec_csr_if,
  bus_if.mst_port    mat_csr_if,
  bus_if.mst_port    csr_if,
  output logic       busy,
  output logic       done,
  output logic       error
);
  typedef enum logic [3:0] {
    S_IDLE, S_WR_ROW, S_GAP0, S_WR_COL, S_GAP1, S_WR_RUN,
    S_WAIT_BUSY, S_WAIT_IDLE, S_GAP2, S_WR_STOP, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_rows;
  logic [7:0]            r_cols;
  logic [15:0]           r_wait_cnt;
  logic                  r_fail;
  logic                  r_vec_valid, r_mat_valid, r_csr_valid, r_done, r_error;
  logic [DATA_WIDTH-1:0] r_vec_data, r_mat_data, r_csr_data;
  logic                  w_vec_valid, w_mat_valid, w_csr_valid, w_done, w_error;
  logic [DATA_WIDTH-1:0] w_vec_data, w_mat_data, w_csr_data;
  logic                  w_accept, w_reject, w_timeout, w_wait_last, w_wait_entry;
  logic [7:0]            w_rows_src;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_reject    = w_accept && ((cmd_rows == 8'd0) || (cmd_cols == 8'd0));
  assign w_wait_last = (r_wait_cnt == TIMEOUT - 16'd1);
  assign w_wait_entry = (w_state_next != r_state) &&
                        ((w_state_next == S_WAIT_BUSY) || (w_state_next == S_WAIT_IDLE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rows      <= 8'd0;
      r_cols      <= 8'd0;
      r_wait_cnt  <= 16'd0;
      r_fail      <= 1'b0;
      r_vec_valid <= 1'b0;
      r_mat_valid <= 1'b0;
      r_csr_valid <= 1'b0;
      r_vec_data  <= '0;
      r_mat_data  <= '0;
      r_csr_data  <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rows <= cmd_rows;
        r_cols <= cmd_cols;
      end
      if (w_wait_entry)
        r_wait_cnt <= 16'd0;
      else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_IDLE))
        r_wait_cnt <= r_wait_cnt + 16'd1;
      if (r_state == S_DONE)
        r_fail <= 1'b0;
      else if (w_reject || w_timeout)
        r_fail <= 1'b1;
      r_vec_valid <= w_vec_valid;
      r_mat_valid <= w_mat_valid;
      r_csr_valid <= w_csr_valid;
      r_vec_data  <= w_vec_data;
      r_mat_data  <= w_mat_data;
      r_csr_data  <= w_csr_data;
      r_done      <= w_done;
      r_error     <= w_error;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE:      if (cmd_valid) w_state_next = w_reject ? S_DONE : S_WR_ROW;
      S_WR_ROW:    if (r_vec_valid && vec_csr_if.ready) w_state_next = S_GAP0;
      S_GAP0:      w_state_next = S_WR_COL;
      S_WR_COL:    if (r_mat_valid && mat_csr_if.ready) w_state_next = S_GAP1;
      S_GAP1:      w_state_next = S_WR_RUN;
      S_WR_RUN:    if (r_csr_valid && csr_if.ready) w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!csr_if.ready) begin
          w_state_next = S_WAIT_IDLE;
        end else if (w_wait_last) begin
          w_state_next = S_GAP2;
          w_timeout    = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (csr_if.ready) begin
          w_state_next = S_GAP2;
        end else if (w_wait_last) begin
          w_state_next = S_GAP2;
          w_timeout    = 1'b1;
        end
      end
      S_GAP2:      w_state_next = S_WR_STOP;
      S_WR_STOP:   if (r_csr_valid && csr_if.ready) w_state_next = S_DONE;
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state, so valid rises on entry to a write state.
  always_comb begin
    w_rows_src  = (r_state == S_IDLE) ? cmd_rows : r_rows;
    w_vec_valid = (w_state_next == S_WR_ROW);
    w_mat_valid = (w_state_next == S_WR_COL);
    w_csr_valid = (w_state_next == S_WR_RUN) || (w_state_next == S_WR_STOP);
    w_vec_data  = w_vec_valid ? DATA_WIDTH'(w_rows_src) : '0;
    w_mat_data  = w_mat_valid ? DATA_WIDTH'(r_cols) : '0;
    w_csr_data  = (w_state_next == S_WR_RUN) ? DATA_WIDTH'(1) : '0;
    w_done      = (w_state_next == S_DONE);
    w_error     = w_done && (r_fail || w_reject);
  end

  assign vec_csr_if.valid = r_vec_valid;
  assign vec_csr_if.data  = r_vec_data;
  assign mat_csr_if.valid = r_mat_valid;
  assign mat_csr_if.data  = r_mat_data;
  assign csr_if.valid     = r_csr_valid;
  assign csr_if.data      = r_csr_data;
  assign cmd_ready        = (r_state == S_IDLE);
  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;
  assign error            = r_error;
endmodule

// File: tb/tb_csr_launcher.sv
// Bench for csr_launcher: bus responders, an accelerator ready model, a bus monitor
// and a directed-plus-random command sequence checked against a transaction model.
module tb_csr_launcher;
  localparam int          DW = 16;
  localparam logic [15:0] TO = 16'd8;

  typedef struct packed {
    logic [1:0]  port;
    logic [15:0] data;
  } wr_t;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_rows;
  logic [7:0] cmd_cols;
  logic       busy;
  logic       done;
  logic       error;

  bus_if #(.DATA_WIDTH(DW)) vec_if ();
  bus_if #(.DATA_WIDTH(DW)) mat_if ();
  bus_if #(.DATA_WIDTH(DW)) csr_bus ();

  csr_launcher #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rows   (cmd_rows),
    .cmd_cols   (cmd_cols),
    .vec_csr_if (vec_if),
    .mat_csr_if (mat_if),
    .csr_if     (csr_bus),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  // Responder / accelerator knobs, written only by the main sequence.
  int  vec_stall = 0;
  int  mat_stall = 0;
  int  acc_h = 0;
  int  acc_l = 0;
  // Monitor results, written only by the monitor.
  wr_t writes[$];
  int  done_cnt = 0;
  int  done_cyc = 0;
  bit  done_err = 0;
  int  run_cyc = 0;
  int  stop_cyc = 0;
  bit  run_seen = 0;
  int  mat_last = 0;
  int  vcyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input int p, input logic [15:0] d);
    wr_t w;
    w.port = 2'(p);
    w.data = d;
    return w;
  endfunction

  // Bus responders and accelerator: write ports stall a programmed number of cycles
  // per write; the accelerator's ready stays high acc_h cycles after run, then low acc_l cycles.
  initial begin
    int vc = 0;
    int mc = 0;
    int k;
    vec_if.ready  = 1'b1;
    mat_if.ready  = 1'b1;
    csr_bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (vec_if.valid && vc < vec_stall) begin
        vec_if.ready = 1'b0;
        vc++;
      end else begin
        vec_if.ready = 1'b1;
        if (!vec_if.valid) vc = 0;
      end
      if (mat_if.valid && mc < mat_stall) begin
        mat_if.ready = 1'b0;
        mc++;
      end else begin
        mat_if.ready = 1'b1;
        if (!mat_if.valid) mc = 0;
      end
      k = cyc - run_cyc;
      csr_bus.ready = (run_seen && k >= acc_h + 1 && k <= acc_h + acc_l) ? 1'b0 : 1'b1;
    end
  end

  // Bus monitor: protocol rules every cycle, plus a log of completed writes.
  initial begin
    logic [2:0]  cur_v, cur_r, prev_v, prev_r;
    logic [15:0] cur_d [3];
    logic [15:0] prev_d [3];
    bit          hs, prev_hs;
    int          mat_len;
    prev_v = '0; prev_r = '0; prev_hs = 0; mat_len = 0;
    for (int p = 0; p < 3; p++) prev_d[p] = '0;
    forever begin
      @(negedge clk);
      cur_v = {csr_bus.valid, mat_if.valid, vec_if.valid};
      cur_r = {csr_bus.ready, mat_if.ready, vec_if.ready};
      cur_d[0] = vec_if.data;
      cur_d[1] = mat_if.data;
      cur_d[2] = csr_bus.data;
      if (reset) begin
        prev_v = '0; prev_r = '0; prev_hs = 0; mat_len = 0;
        run_seen = 0;
      end else begin
        check("one_valid", int'($countones(cur_v) <= 1), 1);
        check("error_only_with_done", int'(error && !done), 0);
        if (prev_hs) check("gap_after_write", int'(cur_v), 0);
        hs = 0;
        for (int p = 0; p < 3; p++) begin
          if (!cur_v[p]) check("data_zero_when_idle", int'(cur_d[p]), 0);
          if (prev_v[p] && !prev_r[p]) begin
            check("hold_valid", int'(cur_v[p]), 1);
            check("hold_data", int'(cur_d[p]), int'(prev_d[p]));
          end
          if (cur_v[p] && cur_r[p]) begin
            hs = 1;
            check("fresh_edge", int'(!prev_v[p] || (!prev_r[p] && prev_d[p] == cur_d[p])), 1);
            writes.push_back(mk(p, cur_d[p]));
            if (p == 2 && cur_d[p] == 16'd1) begin
              run_seen = 1;
              run_cyc  = cyc;
            end
            if (p == 2 && cur_d[p] == 16'd0) stop_cyc = cyc;
            if (p == 1) mat_last = mat_len + 1;
          end
        end
        mat_len = cur_v[1] ? mat_len + 1 : 0;
        if (cur_v != 3'b000) vcyc++;
        if (done) begin
          done_cnt++;
          done_err = error;
          done_cyc = cyc;
          run_seen = 0;
        end
        prev_v = cur_v; prev_r = cur_r; prev_d = cur_d; prev_hs = hs;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] r, input logic [7:0] c, output int acc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_rows  = r;
    cmd_cols  = c;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("cmd_accepted", int'(acc >= 0), 1);
  endtask

  task automatic wait_done(input int cnt0);
    int i = 0;
    while (done_cnt == cnt0 && i < 3000) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("done_arrives", int'(done_cnt != cnt0), 1);
    @(negedge clk);
    #1;
    check("done_one_cycle", int'(done), 0);
    check("done_count", done_cnt - cnt0, 1);
  endtask

  // Reference: a non-empty command writes rows, cols, run=1, run=0 in that order; it
  // fails if empty, or if either awaited ready level is not seen within TO cycles of
  // entering its wait (ready never falling counts as not seen).
  task automatic run_cmd(input logic [7:0] r, input logic [7:0] c, input int vs, input int ms,
                         input int h, input int l, input string tag, output int acc);
    wr_t exp_q[$];
    bit  exp_err;
    int  base, cnt0, n;
    vec_stall = vs; mat_stall = ms; acc_h = h; acc_l = l;
    base = writes.size();
    cnt0 = done_cnt;
    send_cmd(r, c, acc);
    wait_done(cnt0);
    if (r == 8'd0 || c == 8'd0) begin
      exp_err = 1;
    end else begin
      exp_q.push_back(mk(0, {8'd0, r}));
      exp_q.push_back(mk(1, {8'd0, c}));
      exp_q.push_back(mk(2, 16'd1));
      exp_q.push_back(mk(2, 16'd0));
      exp_err = (h >= int'(TO)) || (l == 0) || (l > int'(TO));
    end
    n = writes.size() - base;
    check({tag, "_num_writes"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check({tag, "_write_port"}, int'(writes[base + i].port), int'(exp_q[i].port));
      check({tag, "_write_data"}, int'(writes[base + i].data), int'(exp_q[i].data));
    end
    check({tag, "_error"}, int'(done_err), int'(exp_err));
    $display("cmd %s rows=%0d cols=%0d h=%0d l=%0d writes=%0d err=%0d", tag, r, c, h, l, n, done_err);
  endtask

  initial begin
    int acc, acc_b, base, cnt0, v0, i;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rows = 8'd0; cmd_cols = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vec_valid", int'(vec_if.valid), 0);
    check("rst_mat_valid", int'(mat_if.valid), 0);
    check("rst_csr_valid", int'(csr_bus.valid), 0);
    check("rst_data", int'(vec_if.data | mat_if.data | csr_bus.data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Nominal launch: ready low for 6 cycles after run.
    run_cmd(8'd4, 8'd3, 0, 0, 0, 6, "nominal", acc);
    check("nominal_run_latency", run_cyc - acc, 5);

    // Column write back-pressured for 10 cycles.
    run_cmd(8'd4, 8'd3, 0, 10, 0, 2, "backpressure", acc);
    check("backpressure_valid_len", mat_last, 11);

    // Zero-size command is rejected without touching the bus.
    v0 = vcyc;
    run_cmd(8'd0, 8'd5, 0, 0, 0, 2, "zero_size", acc);
    check("zero_size_done_latency", done_cyc - acc, 1);
    check("zero_size_no_valid", vcyc - v0, 0);

    // Accelerator never drops ready: timeout, stop still written.
    run_cmd(8'd2, 8'd2, 0, 0, 1000, 0, "timeout", acc);
    check("timeout_stop_window", int'((stop_cyc - run_cyc >= 9) && (stop_cyc - run_cyc <= 10)), 1);

    // Reset while the row write is stalled.
    vec_stall = 100;
    cnt0 = done_cnt;
    base = writes.size();
    send_cmd(8'd5, 8'd6, acc);
    i = 0;
    while (!vec_if.valid && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("midreset_valid_seen", int'(vec_if.valid), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_valid", int'(vec_if.valid), 0);
    check("midreset_data", int'(vec_if.data), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_cmd_ready", int'(cmd_ready), 1);
    #1;
    check("midreset_no_done", done_cnt - cnt0, 0);
    check("midreset_no_write", writes.size() - base, 0);
    run_cmd(8'd4, 8'd3, 0, 0, 0, 6, "after_reset", acc);

    // Command held high across completion of the previous one.
    vec_stall = 0; mat_stall = 0; acc_h = 2; acc_l = 3;
    cnt0 = done_cnt;
    base = writes.size();
    send_cmd(8'd7, 8'd2, acc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_rows = 8'd9; cmd_cols = 8'd1;
    acc_b = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc_b = cyc;
        break;
      end
    end
    #1;
    check("held_first_idle", acc_b - done_cyc, 1);
    check("held_first_done", done_cnt - cnt0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(cnt0 + 1);
    check("held_num_writes", writes.size() - base, 8);
    if (writes.size() - base == 8) begin
      check("held_a_rows", int'(writes[base].data), 7);
      check("held_b_rows", int'(writes[base + 4].data), 9);
      check("held_b_cols", int'(writes[base + 5].data), 1);
    end
    $display("cmd held rows=9 cols=1 accepted_at=%0d", acc_b);

    // Randomized commands, stalls and accelerator timing.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] rr, cc;
      rr = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      cc = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_cmd(rr, cc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 11)), "random", acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
